rr_csr_regs: RTL
================

# rr_csr_regs

Control/status register responder for the record/replay (RR) logic, attached to one cfg_bus port of the OCL slave (256 B window). It accepts single-cycle `wr`/`rd` request pulses and returns a single-cycle `ack` with `rdata` after a fixed, parameterised latency. It holds the RR control bits and counts logging-bus beats and stall cycles for software.

## Interface
- ACK_LATENCY, 2: cycles from request pulse to `ack` pulse; legal range 1..15.
- RR_ID, 32'h5252_0001: constant returned by the ID register.
- clk  in  1  clock.
- sync_rst_n  in  1  reset, asynchronous, active-low.
- sh_cl_flr_assert_q  in  1  function-level reset, synchronous, level.
- cfg_bus  cfg_bus_t.master  -  request/response port:
  - Inputs: addr[31:0], wdata[31:0], wr, rd.
  - Outputs: ack, rdata[31:0].
- log_valid  in  1  valid of the monitored logging bus.
- log_ready  in  1  ready of the monitored logging bus.
- rr_busy  in  1  status from RR engine.
- record_en  out  1  CTRL[0].
- replay_en  out  1  CTRL[1].
- soft_rst  out  1  one-cycle pulse.

## Operation
- Decode uses addr[7:0]; addr[31:8] ignored. Registers (word offsets):
  - 0x00 CTRL, RW: bit0 record_en, bit1 replay_en, bit2 soft_rst, self-clearing and read as 0.
  - 0x04 STATUS, RO: bit0 rr_busy, bit1 record_en, bit2 replay_en.
  - 0x08 BEATS_LO, RO: low word of 64-bit beat counter. Reading it latches bits [63:32] into a shadow register.
  - 0x0C BEATS_HI, RO: returns the shadow.
  - 0x10 STALL, RW: 32-bit stall counter, saturating at 32'hFFFF_FFFF. Any write clears it.
  - 0x14 SCRATCH, RW.
  - 0x18 ID, RO: RR_ID.
  - All other offsets: writes dropped, reads return 32'hdead_beef.
- Counters:
  - Beat counter increments when log_valid && log_ready.
  - Stall counter increments when log_valid && !log_ready.
  - soft_rst pulse clears both counters and the shadow.
  - Clear and increment in the same cycle: clear wins, result is 0.
- FSM states:
  - IDLE: wr or rd pulse → WAIT. Latch addr, wdata, and direction. The write commits to the register in the cycle after the pulse; a read samples its value in that same cycle.
  - WAIT: latency counter counts down; at terminal count → ACK.
  - ACK: ack=1 for exactly one cycle → IDLE.
- Boundary rules:
  - wr and rd in the same cycle: write wins, read dropped.
  - Pulses arriving in WAIT or ACK are ignored.
  - FLR asserted: CTRL and SCRATCH clear to 0; counters and shadow clear. An in-flight access still completes and issues its ack.
  - A write to CTRL in the same cycle as FLR: FLR wins.

## Timing
- Reset values: ack=0, rdata=0, record_en=0, replay_en=0, soft_rst=0. All registers, counters, shadow and FSM are reset, FSM in IDLE.
- Request pulse on cycle T → ack on cycle T+ACK_LATENCY+1.
- rdata is valid in the ack cycle and held until the next ack.
- For writes, rdata is unchanged.
- record_en and replay_en update at T+2 (one cycle after commit).
- soft_rst pulses high at T+2 for one cycle.
- Back-to-back accesses: the next pulse is accepted in the cycle after ack at the earliest.
- Read data reflects counter values at commit cycle T+1, not at ack.

## Structure
- Package rr_csr_pkg holds:
  - Register offset localparams.
  - CTRL/STATUS bit-position constants.
  - The DEADBEEF default constant.
  - The FSM enum typedef {IDLE, WAIT, ACK}.
- Sub-module rr_sat_counter (parameterised width, saturate-enable, inc/clr inputs, clr priority) is instantiated twice: 64-bit non-saturating and 32-bit saturating.

## Test plan
- Reset, then read 0x18 → ack at T+3 (ACK_LATENCY=2), rdata=32'h5252_0001. Read 0x40 → 32'hdead_beef.
- Write 0x00=32'h3 → record_en=1 and replay_en=1 at T+2. Read 0x00 → 32'h3. Write 0x00=32'h4 → soft_rst one-cycle pulse, counters 0, CTRL reads 0.
- Drive 300 cycles of log_valid=log_ready=1 → BEATS_LO=300. Preset the beat counter to 64'h0000_0001_FFFF_FFFF, add 1 beat, read LO then HI → 0, then 2.
- log_valid=1, log_ready=0 for 50 cycles → STALL=50. Force the counter to 32'hFFFF_FFFE, 5 more stalls → 32'hFFFF_FFFF. Write 0x10 in the same cycle as a stall → reads 0.
- wr and rd pulsed together to 0x14 with wdata=32'hA5A5_A5A5 → single ack, SCRATCH=32'hA5A5_A5A5. A second wr pulse during WAIT → ignored, no extra ack.
- FLR asserted during WAIT of a CTRL write → ack still issued, record_en=0 after FLR. Async reset mid-WAIT → ack stays 0, FSM in IDLE.

Source files
------------

// File: rtl/rr_csr_pkg.sv
// rr_csr_pkg
// Shared definitions for the record/replay CSR responder: register offsets
// within the 256 B cfg window, CTRL/STATUS bit positions, the read value for
// unmapped offsets and the request FSM state type.
package rr_csr_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_BEATS_LO = 8'h08;
  localparam logic [7:0] OFF_BEATS_HI = 8'h0C;
  localparam logic [7:0] OFF_STALL    = 8'h10;
  localparam logic [7:0] OFF_SCRATCH  = 8'h14;
  localparam logic [7:0] OFF_ID       = 8'h18;

  localparam int unsigned CTRL_RECORD_BIT   = 0;
  localparam int unsigned CTRL_REPLAY_BIT   = 1;
  localparam int unsigned CTRL_SOFT_RST_BIT = 2;

  localparam int unsigned STATUS_BUSY_BIT   = 0;
  localparam int unsigned STATUS_RECORD_BIT = 1;
  localparam int unsigned STATUS_REPLAY_BIT = 2;

  localparam logic [31:0] CSR_DEFAULT_RDATA = 32'hdead_beef;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rr_csr_state_e;

endpackage

// File: rtl/rr_sat_counter.sv
// rr_sat_counter
// Up-counter with synchronous clear and optional saturation at all-ones.
// Clear has priority over increment.
// Ports:
//   clk, sync_rst_n : clock, async active-low reset
//   inc             : count one event this cycle
//   clr             : force the count to zero (wins over inc)
//   cnt             : current count
module rr_sat_counter #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(SATURATE && (&cnt_q))) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rr_csr_regs.sv
// rr_csr_regs
// CSR responder for the record/replay logic on one cfg_bus port.
// A wr/rd pulse is latched in IDLE; the access commits in the first WAIT
// cycle and ack is returned ACK_LATENCY+1 cycles after the pulse.
// Ports:
//   clk, sync_rst_n          : clock, async active-low reset
//   sh_cl_flr_assert_q       : function-level reset (sync, level)
//   cfg_addr/wdata/wr/rd     : request side of cfg_bus
//   cfg_ack/cfg_rdata        : response side of cfg_bus
//   log_valid/log_ready      : monitored logging-bus handshake
//   rr_busy                  : RR engine status
//   record_en/replay_en      : CTRL bits
//   soft_rst                 : one-cycle pulse from a CTRL write
//
// state | meaning
// IDLE  | waiting for a wr/rd pulse
// WAIT  | access committed on first cycle, latency countdown
// ACK   | ack high for one cycle, rdata valid
module rr_csr_regs
  import rr_csr_pkg::*;
#(
  parameter int unsigned ACK_LATENCY = 2,
  parameter logic [31:0] RR_ID       = 32'h5252_0001
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        sh_cl_flr_assert_q,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  output logic        cfg_ack,
  output logic [31:0] cfg_rdata,
  input  logic        log_valid,
  input  logic        log_ready,
  input  logic        rr_busy,
  output logic        record_en,
  output logic        replay_en,
  output logic        soft_rst
);

  localparam logic [3:0] LAT_LOAD = 4'(ACK_LATENCY - 1);

  rr_csr_state_e state_q, state_d;
  logic [3:0]    lat_q, lat_d;
  logic          commit_q, commit_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rd_buf_q, rd_buf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [31:0]   scratch_q, scratch_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          soft_rst_q, soft_rst_d;

  logic [63:0] beat_cnt;
  logic [31:0] stall_cnt;
  logic        beat_clr, stall_clr;
  logic        wr_commit, rd_commit;
  logic [31:0] rd_mux;

  logic unused_addr_hi;
  assign unused_addr_hi = ^cfg_addr[31:8];

  assign wr_commit = commit_q && is_wr_q;
  assign rd_commit = commit_q && !is_wr_q;

  assign beat_clr  = sh_cl_flr_assert_q || soft_rst_q;
  assign stall_clr = beat_clr || (wr_commit && (addr_q == OFF_STALL));

  rr_sat_counter #(.WIDTH(64), .SATURATE(1'b0)) u_beat_cnt (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .inc        (log_valid && log_ready),
    .clr        (beat_clr),
    .cnt        (beat_cnt)
  );

  rr_sat_counter #(.WIDTH(32), .SATURATE(1'b1)) u_stall_cnt (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .inc        (log_valid && !log_ready),
    .clr        (stall_clr),
    .cnt        (stall_cnt)
  );

  always_comb begin
    rd_mux = CSR_DEFAULT_RDATA;
    case (addr_q)
      OFF_CTRL: begin
        rd_mux = '0;
        rd_mux[CTRL_RECORD_BIT] = ctrl_q[0];
        rd_mux[CTRL_REPLAY_BIT] = ctrl_q[1];
      end
      OFF_STATUS: begin
        rd_mux = '0;
        rd_mux[STATUS_BUSY_BIT]   = rr_busy;
        rd_mux[STATUS_RECORD_BIT] = ctrl_q[0];
        rd_mux[STATUS_REPLAY_BIT] = ctrl_q[1];
      end
      OFF_BEATS_LO: rd_mux = beat_cnt[31:0];
      OFF_BEATS_HI: rd_mux = shadow_q;
      OFF_STALL:    rd_mux = stall_cnt;
      OFF_SCRATCH:  rd_mux = scratch_q;
      OFF_ID:       rd_mux = RR_ID;
      default:      rd_mux = CSR_DEFAULT_RDATA;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    commit_d   = 1'b0;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_buf_d   = rd_buf_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    ctrl_d     = ctrl_q;
    scratch_d  = scratch_q;
    shadow_d   = shadow_q;
    soft_rst_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_wr || cfg_rd) begin
          state_d  = WAIT;
          lat_d    = LAT_LOAD;
          commit_d = 1'b1;
          is_wr_d  = cfg_wr;  // write wins over a simultaneous read
          addr_d   = cfg_addr[7:0];
          wdata_d  = cfg_wdata;
        end
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = ACK;
          ack_d   = 1'b1;
          // With a one-cycle latency the commit and terminal cycles coincide,
          // so the read value bypasses the buffer.
          if (!is_wr_q) rdata_d = commit_q ? rd_mux : rd_buf_q;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_commit) begin
      case (addr_q)
        OFF_CTRL: begin
          ctrl_d     = {wdata_q[CTRL_REPLAY_BIT], wdata_q[CTRL_RECORD_BIT]};
          soft_rst_d = wdata_q[CTRL_SOFT_RST_BIT];
        end
        OFF_SCRATCH: scratch_d = wdata_q;
        default: ;
      endcase
    end

    if (rd_commit) begin
      rd_buf_d = rd_mux;
      if (addr_q == OFF_BEATS_LO) shadow_d = beat_cnt[63:32];
    end

    if (soft_rst_q) shadow_d = '0;

    // FLR overrides any same-cycle commit; the access itself still acks.
    if (sh_cl_flr_assert_q) begin
      ctrl_d     = '0;
      scratch_d  = '0;
      shadow_d   = '0;
      soft_rst_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      commit_q   <= 1'b0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_buf_q   <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      ctrl_q     <= '0;
      scratch_q  <= '0;
      shadow_q   <= '0;
      soft_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      commit_q   <= commit_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_buf_q   <= rd_buf_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      ctrl_q     <= ctrl_d;
      scratch_q  <= scratch_d;
      shadow_q   <= shadow_d;
      soft_rst_q <= soft_rst_d;
    end
  end

  assign cfg_ack   = ack_q;
  assign cfg_rdata = rdata_q;
  assign record_en = ctrl_q[0];
  assign replay_en = ctrl_q[1];
  assign soft_rst  = soft_rst_q;

endmodule
